// File: rtl/blowfish_pkg.sv
// Shared types and helpers for the Blowfish-family mode engine.
package blowfish_pkg;

    localparam int DEFAULT_ROUNDS = 16;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        FINAL,
        OUT
    } state_e;

    typedef enum logic {
        ECB = 1'b0,
        CBC = 1'b1
    } mode_e;

    // Zero-based p_array slot for subkey Q(j); decryption walks P backwards.
    function automatic int p_sel(input int j, input logic dec, input int p_num);
        return dec ? (p_num - j) : (j - 1);
    endfunction

endpackage

// File: rtl/blowfish_mode_engine.sv
// Iterative Blowfish-family Feistel engine with ECB/CBC chaining.
// One Feistel round per external F-function req/ack transaction.
module blowfish_mode_engine
    import blowfish_pkg::*;
#(
    parameter int BLOCK_W = 128,
    parameter int ROUNDS  = DEFAULT_ROUNDS,
    localparam int HALF_W = BLOCK_W / 2,
    localparam int P_NUM  = ROUNDS + 2
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    skey_ready,
    input  logic [P_NUM*HALF_W-1:0] p_array,
    input  logic                    mode_cbc,
    input  logic                    decrypt,
    input  logic                    iv_load,
    input  logic [BLOCK_W-1:0]      iv_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BLOCK_W-1:0]      in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BLOCK_W-1:0]      out_data,
    output logic                    f_req,
    output logic [HALF_W-1:0]       f_x,
    input  logic                    f_ack,
    input  logic [HALF_W-1:0]       f_y,
    output logic                    busy
);

    localparam int KW = $clog2(ROUNDS + 1);

    state_e               state_q, state_d;
    mode_e                mode_q, mode_d;
    logic                 dec_q, dec_d;
    logic [KW-1:0]        k_q, k_d;
    logic [HALF_W-1:0]    l_q, l_d;
    logic [HALF_W-1:0]    r_q, r_d;
    logic [BLOCK_W-1:0]   raw_q, raw_d;
    logic [BLOCK_W-1:0]   chain_q, chain_d;
    logic [BLOCK_W-1:0]   out_q, out_d;
    logic                 freq_q, freq_d;
    logic                 accept;
    logic [BLOCK_W-1:0]   blk;
    logic [BLOCK_W-1:0]   res;

    function automatic logic [HALF_W-1:0] subkey(input int j, input logic dec);
        return p_array[p_sel(j, dec, P_NUM)*HALF_W +: HALF_W];
    endfunction

    assign in_ready  = (state_q == IDLE) & skey_ready & ~Rst;
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == OUT);
    assign out_data  = out_q;
    assign f_req     = freq_q;
    assign f_x       = l_q;
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        dec_d   = dec_q;
        k_d     = k_q;
        l_d     = l_q;
        r_d     = r_q;
        raw_d   = raw_q;
        chain_d = chain_q;
        out_d   = out_q;
        freq_d  = freq_q;
        blk     = in_data;
        res     = '0;
        unique case (state_q)
            IDLE: begin
                if (iv_load) chain_d = iv_in;
                if (accept) begin
                    // A same-cycle IV load must already whiten this block.
                    if (mode_cbc && !decrypt)
                        blk = in_data ^ (iv_load ? iv_in : chain_q);
                    mode_d     = mode_e'(mode_cbc);
                    dec_d      = decrypt;
                    k_d        = '0;
                    raw_d      = in_data;
                    {l_d, r_d} = blk;
                    state_d    = REQ;
                end
            end
            REQ: begin
                l_d     = l_q ^ subkey(int'(k_q) + 1, dec_q);
                freq_d  = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (f_ack) begin
                    l_d     = r_q ^ f_y;
                    r_d     = l_q;
                    freq_d  = 1'b0;
                    k_d     = k_q + KW'(1);
                    state_d = (k_q == KW'(ROUNDS - 1)) ? FINAL : REQ;
                end
            end
            FINAL: begin
                res = {r_q ^ subkey(ROUNDS + 2, dec_q),
                       l_q ^ subkey(ROUNDS + 1, dec_q)};
                out_d = res;
                if (mode_q == CBC) begin
                    if (dec_q) begin
                        out_d   = res ^ chain_q;
                        chain_d = raw_q;
                    end else begin
                        chain_d = res;
                    end
                end
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            mode_q  <= ECB;
            dec_q   <= 1'b0;
            k_q     <= '0;
            l_q     <= '0;
            r_q     <= '0;
            raw_q   <= '0;
            chain_q <= '0;
            out_q   <= '0;
            freq_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dec_q   <= dec_d;
            k_q     <= k_d;
            l_q     <= l_d;
            r_q     <= r_d;
            raw_q   <= raw_d;
            chain_q <= chain_d;
            out_q   <= out_d;
            freq_q  <= freq_d;
        end
    end

endmodule

// File: tb/tb_blowfish_mode_engine.sv
// Scoreboard bench for blowfish_mode_engine, 64-bit blocks, 16 rounds.
module tb_blowfish_mode_engine;

    localparam int BW = 64;
    localparam int HW = 32;
    localparam int NR = 16;
    localparam int PN = NR + 2;

    logic            Clk = 1'b0;
    logic            Rst;
    logic            skey_ready;
    logic [PN*HW-1:0] p_array;
    logic            mode_cbc;
    logic            decrypt;
    logic            iv_load;
    logic [BW-1:0]   iv_in;
    logic            in_valid;
    logic            in_ready;
    logic [BW-1:0]   in_data;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [BW-1:0]   out_data;
    logic            f_req;
    logic [HW-1:0]   f_x;
    logic            f_ack = 1'b0;
    logic [HW-1:0]   f_y = '0;
    logic            busy;

    blowfish_mode_engine #(.BLOCK_W(BW), .ROUNDS(NR)) dut (
        .Clk(Clk), .Rst(Rst), .skey_ready(skey_ready), .p_array(p_array),
        .mode_cbc(mode_cbc), .decrypt(decrypt), .iv_load(iv_load),
        .iv_in(iv_in), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .f_req(f_req), .f_x(f_x), .f_ack(f_ack),
        .f_y(f_y), .busy(busy)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad = 0;
    logic [HW-1:0] p_arr [PN];
    logic [BW-1:0] expq [$];
    logic [BW-1:0] chain_m;
    logic [BW-1:0] iv_val = 64'hA5A5A5A5A5A5A5A5;
    bit  fmode = 0;
    int  ack_cnt = 0;
    int  stall_round = 0;
    int  stall_len = 0;
    int  bp_len = 0;

    always_comb begin
        for (int i = 0; i < PN; i++) p_array[i*HW +: HW] = p_arr[i];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [HW-1:0] bench_f(input logic [HW-1:0] x);
        logic [HW-1:0] rot;
        rot = {x[24:0], x[31:25]};
        return fmode ? ((rot + 32'h9E3779B9) ^ (x >> 3)) : '0;
    endfunction

    // Textbook Feistel formulation: xor, F, swap; then unswap and whiten.
    function automatic logic [BW-1:0] bf_core(input logic [BW-1:0] b, input bit dec);
        logic [HW-1:0] xl, xr, t;
        logic [HW-1:0] pk [PN];
        for (int i = 0; i < PN; i++) pk[i] = dec ? p_arr[PN-1-i] : p_arr[i];
        xl = b[63:32];
        xr = b[31:0];
        for (int i = 0; i < NR; i++) begin
            xl = xl ^ pk[i];
            xr = xr ^ bench_f(xl);
            t = xl; xl = xr; xr = t;
        end
        t = xl; xl = xr; xr = t;
        xr = xr ^ pk[NR];
        xl = xl ^ pk[NR+1];
        return {xl, xr};
    endfunction

    function automatic logic [BW-1:0] cbc_enc(input logic [BW-1:0] d);
        logic [BW-1:0] r;
        r = bf_core(d ^ chain_m, 1'b0);
        chain_m = r;
        return r;
    endfunction

    // F-function responder with an optional stall in one chosen round.
    int wcnt = 0;
    logic [HW-1:0] fx_first;
    always @(negedge Clk) begin
        f_ack = 1'b0;
        if (Rst) begin
            wcnt = 0;
        end else if (f_req) begin
            if (wcnt == 0) fx_first = f_x;
            if (wcnt >= ((ack_cnt == stall_round - 1) ? stall_len : 0)) begin
                if (wcnt > 0) chk("fx_stable", f_x, fx_first);
                f_ack = 1'b1;
                f_y = bench_f(f_x);
                ack_cnt++;
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end
    end

    // Output monitor: optional backpressure, then scoreboard compare.
    int bp_cnt = 0;
    bit bp_rdy = 0;
    logic [BW-1:0] held;
    always @(negedge Clk) begin
        if (Rst) begin
            bp_cnt = 0;
        end else if (out_valid) begin
            if (bp_cnt < bp_len) begin
                if (bp_cnt == 0) begin
                    held = out_data;
                    bp_rdy = 0;
                end
                if (in_ready) bp_rdy = 1;
                out_ready = 1'b0;
                bp_cnt++;
            end else begin
                if (bp_len > 0) begin
                    chk("bp_hold", out_data, held);
                    chk("bp_in_ready", 64'(bp_rdy), 64'd0);
                end
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: got %h want none", out_data);
                end else begin
                    chk("sb_data", out_data, expq.pop_front());
                end
                out_ready = 1'b1;
                bp_cnt = 0;
            end
        end
    end

    task automatic send(input logic [BW-1:0] d, input bit cbc, input bit dec,
                        input bit ivl, input bit glitch,
                        input logic [BW-1:0] exp, output int lat);
        int n;
        expq.push_back(exp);
        n = 0;
        @(negedge Clk);
        while (!in_ready && n < 200) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL in_ready_timeout: got 0 want 1");
        end
        in_data  = d;
        mode_cbc = cbc;
        decrypt  = dec;
        iv_load  = ivl;
        in_valid = 1'b1;
        @(posedge Clk);
        #1;
        in_valid = 1'b0;
        iv_load  = 1'b0;
        ack_cnt  = 0;
        lat = 0;
        do begin
            @(negedge Clk);
            lat++;
            if (glitch && lat == 1) begin
                iv_in = ~iv_val;
                iv_load = 1'b1;
            end else if (glitch && lat == 2) begin
                iv_in = iv_val;
                iv_load = 1'b0;
            end
        end while (!out_valid && lat < 300);
        if (lat >= 300) begin
            total++; bad++;
            $display("FAIL out_valid_timeout: got 0 want 1");
        end
        n = 0;
        while (out_valid && n < 100) begin
            @(negedge Clk);
            n++;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_f_req"}, 64'(f_req), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_out_data"}, out_data, 64'd0);
        chk({tag, "_f_x"}, 64'(f_x), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] pt [4];
        logic [BW-1:0] ct [4];
        logic [BW-1:0] e;
        int lat;
        int n;
        pt[0] = 64'h0011223344556677;
        pt[1] = 64'h8899AABBCCDDEEFF;
        pt[2] = 64'hDEADBEEFCAFEF00D;
        pt[3] = 64'h0F1E2D3C4B5A6978;
        Rst = 1'b1;
        skey_ready = 1'b1;
        mode_cbc = 1'b0;
        decrypt = 1'b0;
        iv_load = 1'b0;
        iv_in = iv_val;
        in_valid = 1'b0;
        in_data = '0;
        for (int i = 0; i < PN; i++) p_arr[i] = '0;
        repeat (2) @(posedge Clk);
        #1;
        chk_reset_outputs("rst");
        @(negedge Clk);
        Rst = 1'b0;

        // Zero keys, zero F: 16 swaps cancel, final unswap exchanges halves.
        send(64'h0123456789ABCDEF, 0, 0, 0, 0, 64'h89ABCDEF01234567, lat);
        chk("lat_zero_wait", 64'(lat), 64'd34);

        // No accept while the key schedule is not ready.
        @(negedge Clk);
        skey_ready = 1'b0;
        in_valid = 1'b1;
        #1;
        chk("in_ready_nokey", 64'(in_ready), 64'd0);
        @(negedge Clk);
        chk("busy_nokey", 64'(busy), 64'd0);
        in_valid = 1'b0;
        skey_ready = 1'b1;
        #1;
        chk("in_ready_key", 64'(in_ready), 64'd1);

        // P(j)=j, zero F: halves pick up xor of odd / even subkeys.
        for (int i = 0; i < PN; i++) p_arr[i] = 32'(i + 1);
        send(64'h0123456789ABCDEF, 0, 0, 0, 0, 64'h89ABCDED01234576, lat);
        send(64'h89ABCDED01234576, 0, 1, 0, 0, 64'h0123456789ABCDEF, lat);

        // Non-trivial keys and F for the chaining tests.
        fmode = 1;
        for (int i = 0; i < PN; i++) p_arr[i] = 32'h243F6A88 ^ (32'(i) * 32'h01000193);
        chain_m = iv_val;
        for (int i = 0; i < 3; i++) begin
            ct[i] = cbc_enc(pt[i]);
            send(pt[i], 1, 0, (i == 0), 0, ct[i], lat);
        end
        ct[3] = cbc_enc(pt[3]);
        send(pt[3], 1, 0, 0, 1, ct[3], lat);

        @(negedge Clk);
        iv_load = 1'b1;
        @(negedge Clk);
        iv_load = 1'b0;
        for (int i = 0; i < 4; i++) send(ct[i], 1, 1, 0, 0, pt[i], lat);
        // Chain now holds ct[3]; D(ct[0]) is pt[0]^IV.
        send(ct[0], 1, 1, 0, 0, pt[0] ^ iv_val ^ ct[3], lat);

        // F stalls 5 cycles in round 3.
        stall_round = 3;
        stall_len = 5;
        e = bf_core(64'h1122334455667788, 1'b0);
        send(64'h1122334455667788, 0, 0, 0, 0, e, lat);
        chk("lat_stall", 64'(lat), 64'd39);
        stall_round = 0;
        stall_len = 0;

        // Output backpressure for 10 cycles.
        bp_len = 10;
        e = bf_core(64'hCAFEBABE00C0FFEE, 1'b1);
        send(64'hCAFEBABE00C0FFEE, 0, 1, 0, 0, e, lat);
        chk("lat_bp", 64'(lat), 64'd34);
        bp_len = 0;

        // Abort a block in round 7 with a one-cycle reset.
        @(negedge Clk);
        in_data = 64'h5555AAAA5555AAAA;
        mode_cbc = 1'b0;
        decrypt = 1'b0;
        in_valid = 1'b1;
        @(posedge Clk);
        #1;
        in_valid = 1'b0;
        ack_cnt = 0;
        n = 0;
        while (ack_cnt < 6 && n < 200) begin
            @(negedge Clk);
            n++;
        end
        chk("round7_reached", 64'(ack_cnt), 64'd6);
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        chk_reset_outputs("abort");
        @(negedge Clk);
        Rst = 1'b0;
        fmode = 0;
        for (int i = 0; i < PN; i++) p_arr[i] = 32'(i + 1);
        send(64'hFFFFFFFF00000000, 0, 0, 0, 0, 64'h00000002FFFFFFEE, lat);
        chk("lat_after_abort", 64'(lat), 64'd34);

        repeat (3) @(negedge Clk);
        chk("sb_empty", 64'(expq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
